// File: rtl/ram_2rw_chan_pkg.sv
// ============================================================================
// Module      : ram_2rw_chan_pkg
// Description : Shared width helpers for the ram_2rw channel adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_2rw_chan_pkg;

    // Width of one response entry: {is_wr, data}.
    function automatic int resp_width(input int data_width);
        return data_width + 1;
    endfunction

    // FIFO occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_chan_port.sv
// ============================================================================
// Module      : ram_chan_port
// Description : One RAM port: request strobes, pending stage, response FIFO
//               and credit-based request backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_chan_port
    import ram_2rw_chan_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_block,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    input  logic                  i_req_we,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_data,
    output logic                  o_resp_is_wr,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_wr_en,
    output logic                  o_ram_rd_en,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data
);

    localparam int            CW      = cnt_width(RESP_DEPTH);
    localparam int            PW      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int            RW      = resp_width(DATA_WIDTH);
    localparam logic [CW:0]   c_DEPTH = (CW+1)'(RESP_DEPTH);
    localparam logic [PW-1:0] c_LAST  = PW'(RESP_DEPTH - 1);

    typedef struct packed {
        logic                  is_wr;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic          r_pend_vld;
    logic          r_pend_wr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    resp_t         r_mem [RESP_DEPTH];

    logic          w_fire;
    logic          w_pop;
    logic          w_push;
    logic [CW:0]   w_inflight;
    resp_t         w_push_ent;
    resp_t         w_head;
    logic [RW-1:0] w_head_bits;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == c_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_pop  = (r_count != '0) & i_resp_ready;
    assign w_push = r_pend_vld;

    // Buffered plus in-flight entries, less this cycle's pop: a new request is
    // taken only if its response is guaranteed a slot.
    assign w_inflight  = {1'b0, r_count} + (CW+1)'(r_pend_vld) - (CW+1)'(w_pop);
    assign o_req_ready = ~rst & ~i_block & (w_inflight < c_DEPTH);
    assign w_fire      = i_req_valid & o_req_ready;

    assign o_ram_wr_en = w_fire & i_req_we;
    assign o_ram_rd_en = w_fire & ~i_req_we;
    assign o_ram_addr  = rst ? '0 : i_req_addr;
    assign o_ram_data  = rst ? '0 : i_req_data;

    assign w_push_ent.is_wr = r_pend_wr;
    assign w_push_ent.data  = r_pend_wr ? {DATA_WIDTH{1'b0}} : i_ram_rd_data;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_bits  = o_resp_valid ? w_head : {RW{1'b0}};
    assign o_resp_valid = (r_count != '0);
    assign o_resp_is_wr = w_head_bits[RW-1];
    assign o_resp_data  = w_head_bits[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend_wr  <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_pend_vld <= w_fire;
            r_pend_wr  <= w_fire & i_req_we;
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_ent;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_2rw_chan_adapter.sv
// ============================================================================
// Module      : ram_2rw_chan_adapter
// Description : Valid/ready front-end for the dual-port ram_2rw memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_2rw_chan_adapter
    import ram_2rw_chan_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_data_0,
    input  logic                  req_we_0,
    output logic                  resp_valid_0,
    input  logic                  resp_ready_0,
    output logic [DATA_WIDTH-1:0] resp_data_0,
    output logic                  resp_is_wr_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic                  ram_wr_en_0,
    output logic                  ram_rd_en_0,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_0,

    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_data_1,
    input  logic                  req_we_1,
    output logic                  resp_valid_1,
    input  logic                  resp_ready_1,
    output logic [DATA_WIDTH-1:0] resp_data_1,
    output logic                  resp_is_wr_1,
    output logic [ADDR_WIDTH-1:0] ram_addr_1,
    output logic [DATA_WIDTH-1:0] ram_data_1,
    output logic                  ram_wr_en_1,
    output logic                  ram_rd_en_1,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_1
);

    logic w_fire_0;
    logic w_block_1;

    // Port 0 wins a same-address write/write race; port 1 retries next cycle.
    assign w_fire_0  = req_valid_0 & req_ready_0;
    assign w_block_1 = w_fire_0 & req_we_0 & req_valid_1 & req_we_1 &
                       (req_addr_0 == req_addr_1);

    ram_chan_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) u_port_0 (
        .clk           (clk),
        .rst           (rst),
        .i_block       (1'b0),
        .i_req_valid   (req_valid_0),
        .o_req_ready   (req_ready_0),
        .i_req_addr    (req_addr_0),
        .i_req_data    (req_data_0),
        .i_req_we      (req_we_0),
        .o_resp_valid  (resp_valid_0),
        .i_resp_ready  (resp_ready_0),
        .o_resp_data   (resp_data_0),
        .o_resp_is_wr  (resp_is_wr_0),
        .o_ram_addr    (ram_addr_0),
        .o_ram_data    (ram_data_0),
        .o_ram_wr_en   (ram_wr_en_0),
        .o_ram_rd_en   (ram_rd_en_0),
        .i_ram_rd_data (ram_rd_data_0)
    );

    ram_chan_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESP_DEPTH (RESP_DEPTH)
    ) u_port_1 (
        .clk           (clk),
        .rst           (rst),
        .i_block       (w_block_1),
        .i_req_valid   (req_valid_1),
        .o_req_ready   (req_ready_1),
        .i_req_addr    (req_addr_1),
        .i_req_data    (req_data_1),
        .i_req_we      (req_we_1),
        .o_resp_valid  (resp_valid_1),
        .i_resp_ready  (resp_ready_1),
        .o_resp_data   (resp_data_1),
        .o_resp_is_wr  (resp_is_wr_1),
        .o_ram_addr    (ram_addr_1),
        .o_ram_data    (ram_data_1),
        .o_ram_wr_en   (ram_wr_en_1),
        .o_ram_rd_en   (ram_rd_en_1),
        .i_ram_rd_data (ram_rd_data_1)
    );

endmodule

`default_nettype wire

// File: tb/tb_ram_2rw_chan_adapter.sv
// ============================================================================
// Module      : tb_ram_2rw_chan_adapter
// Description : Directed and random checks of ram_2rw_chan_adapter against a
//               transaction-level model with a behavioural RAM attached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_2rw_chan_adapter;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid, req_we, resp_ready;
    logic [1:0] req_ready, resp_valid, resp_is_wr, ram_wr_en, ram_rd_en;
    logic [4:0] req_addr    [2];
    logic [3:0] req_data    [2];
    logic [3:0] resp_data   [2];
    logic [4:0] ram_addr    [2];
    logic [3:0] ram_data    [2];
    logic [3:0] ram_rd_data [2];

    logic [3:0] ram     [32] = '{default: 4'h0};
    logic [3:0] ref_mem [32] = '{default: 4'h0};

    typedef struct {
        int         p;
        int         t;
        logic       w;
        logic [3:0] d;
    } exp_t;

    exp_t       q [$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       acc    [2];
    logic [3:0] last_d [2];
    logic       last_w [2];

    ram_2rw_chan_adapter #(
        .DATA_WIDTH (4),
        .SIZE       (32),
        .ADDR_WIDTH (5),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_0   (req_valid[0]),
        .req_ready_0   (req_ready[0]),
        .req_addr_0    (req_addr[0]),
        .req_data_0    (req_data[0]),
        .req_we_0      (req_we[0]),
        .resp_valid_0  (resp_valid[0]),
        .resp_ready_0  (resp_ready[0]),
        .resp_data_0   (resp_data[0]),
        .resp_is_wr_0  (resp_is_wr[0]),
        .ram_addr_0    (ram_addr[0]),
        .ram_data_0    (ram_data[0]),
        .ram_wr_en_0   (ram_wr_en[0]),
        .ram_rd_en_0   (ram_rd_en[0]),
        .ram_rd_data_0 (ram_rd_data[0]),
        .req_valid_1   (req_valid[1]),
        .req_ready_1   (req_ready[1]),
        .req_addr_1    (req_addr[1]),
        .req_data_1    (req_data[1]),
        .req_we_1      (req_we[1]),
        .resp_valid_1  (resp_valid[1]),
        .resp_ready_1  (resp_ready[1]),
        .resp_data_1   (resp_data[1]),
        .resp_is_wr_1  (resp_is_wr[1]),
        .ram_addr_1    (ram_addr[1]),
        .ram_data_1    (ram_data[1]),
        .ram_wr_en_1   (ram_wr_en[1]),
        .ram_rd_en_1   (ram_rd_en[1]),
        .ram_rd_data_1 (ram_rd_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with registered read data, read-before-write.
    always @(posedge clk) begin
        if (ram_rd_en[0]) ram_rd_data[0] <= ram[ram_addr[0]];
        if (ram_rd_en[1]) ram_rd_data[1] <= ram[ram_addr[1]];
        if (ram_wr_en[0]) ram[ram_addr[0]] <= ram_data[0];
        if (ram_wr_en[1]) ram[ram_addr[1]] <= ram_data[1];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we, input int a, input int d);
        req_valid[p] = v;
        req_we[p]    = we;
        req_addr[p]  = 5'(a);
        req_data[p]  = 4'(d);
    endtask

    // One clock: check outputs mid-cycle against the model, record accepted
    // requests, then advance past the next rising edge.
    task automatic step();
        int         idx   [2];
        int         outst [2];
        logic       ev    [2];
        logic       pop   [2];
        logic       er    [2];
        logic [3:0] rdv   [2];
        logic       coll;
        exp_t       e;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            idx[p]   = -1;
            outst[p] = 0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].p == p) begin
                    outst[p]++;
                    if (idx[p] < 0) idx[p] = i;
                end
            end
            ev[p] = (idx[p] >= 0) && (q[idx[p]].t + 2 <= cyc);
            chk($sformatf("p%0d_resp_valid c%0d", p, cyc), 32'(resp_valid[p]), 32'(ev[p]));
            if (ev[p]) begin
                chk($sformatf("p%0d_resp_data c%0d", p, cyc), 32'(resp_data[p]), 32'(q[idx[p]].d));
                chk($sformatf("p%0d_resp_is_wr c%0d", p, cyc), 32'(resp_is_wr[p]), 32'(q[idx[p]].w));
            end
            pop[p] = ev[p] & resp_ready[p];
            if (pop[p]) begin
                last_d[p] = q[idx[p]].d;
                last_w[p] = q[idx[p]].w;
            end
        end
        er[0] = (outst[0] - int'(pop[0])) < DEPTH;
        coll  = req_valid[0] & er[0] & req_we[0] & req_valid[1] & req_we[1] &
                (req_addr[0] == req_addr[1]);
        er[1] = ((outst[1] - int'(pop[1])) < DEPTH) && !coll;
        for (int p = 0; p < 2; p++) begin
            acc[p] = req_valid[p] & er[p];
            chk($sformatf("p%0d_req_ready c%0d", p, cyc), 32'(req_ready[p]), 32'(er[p]));
            chk($sformatf("p%0d_ram_wr_en c%0d", p, cyc), 32'(ram_wr_en[p]), 32'(acc[p] & req_we[p]));
            chk($sformatf("p%0d_ram_rd_en c%0d", p, cyc), 32'(ram_rd_en[p]), 32'(acc[p] & ~req_we[p]));
            rdv[p] = ref_mem[req_addr[p]];
        end
        if (pop[0] && pop[1]) begin
            if (idx[0] > idx[1]) begin q.delete(idx[0]); q.delete(idx[1]); end
            else begin q.delete(idx[1]); q.delete(idx[0]); end
        end else if (pop[0]) q.delete(idx[0]);
        else if (pop[1]) q.delete(idx[1]);
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                e.p = p;
                e.t = cyc;
                e.w = req_we[p];
                e.d = req_we[p] ? 4'h0 : rdv[p];
                q.push_back(e);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (acc[p] && req_we[p]) ref_mem[req_addr[p]] = req_data[p];
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic drain();
        idle();
        resp_ready = 2'b11;
        repeat (5) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int   n0, n1, n_acc;
        logic hv [2];
        logic hwe [2];
        int   ha [2];
        int   hd [2];

        rst        = 1'b1;
        resp_ready = 2'b11;
        drive(0, 1'b1, 1'b1, 5, 15);
        drive(1, 1'b1, 1'b0, 9, 15);
        #2;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_p%0d_req_ready", p), 32'(req_ready[p]), 32'd0);
            chk($sformatf("rst_p%0d_resp_valid", p), 32'(resp_valid[p]), 32'd0);
            chk($sformatf("rst_p%0d_resp_data", p), 32'(resp_data[p]), 32'd0);
            chk($sformatf("rst_p%0d_resp_is_wr", p), 32'(resp_is_wr[p]), 32'd0);
            chk($sformatf("rst_p%0d_ram_strobes", p), 32'({ram_wr_en[p], ram_rd_en[p]}), 32'd0);
            chk($sformatf("rst_p%0d_ram_addr", p), 32'(ram_addr[p]), 32'd0);
            chk($sformatf("rst_p%0d_ram_data", p), 32'(ram_data[p]), 32'd0);
        end
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_p0_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rel_p1_req_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;

        // Basic write then read on port 0.
        drive(0, 1'b1, 1'b1, 5, 4'hA);
        step();
        chk("basic_wr_acc", 32'(acc[0]), 32'd1);
        drive(0, 1'b1, 1'b0, 5, 0);
        step();
        drain();
        chk("basic_rd_data", 32'(last_d[0]), 32'hA);

        // Backpressure on port 1: preload 10..13, then issue four reads.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b1, 10 + i, 3 + i);
            step();
        end
        drain();
        resp_ready[1] = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1, 1'b1, 1'b0, 10 + n_acc, 0);
            step();
            if (acc[1]) n_acc++;
        end
        chk("bp_accepted_stalled", 32'(n_acc), 32'd2);
        resp_ready[1] = 1'b1;
        for (int c = 0; c < 20 && n_acc < 4; c++) begin
            drive(1, 1'b1, 1'b0, 10 + n_acc, 0);
            step();
            if (acc[1]) n_acc++;
        end
        chk("bp_accepted_all", 32'(n_acc), 32'd4);
        drain();
        chk("bp_last_data", 32'(last_d[1]), 32'h6);

        // Same-address write collision.
        drive(0, 1'b1, 1'b1, 3, 1);
        drive(1, 1'b1, 1'b1, 3, 2);
        step();
        chk("coll_p0_acc", 32'(acc[0]), 32'd1);
        chk("coll_p1_stall", 32'(acc[1]), 32'd0);
        drive(0, 1'b0, 1'b0, 0, 0);
        step();
        chk("coll_p1_retry", 32'(acc[1]), 32'd1);
        drain();
        drive(0, 1'b1, 1'b0, 3, 0);
        step();
        drain();
        chk("coll_final", 32'(last_d[0]), 32'h2);

        // Cross-port read-before-write.
        drive(0, 1'b1, 1'b1, 7, 4);
        step();
        drive(0, 1'b1, 1'b1, 7, 9);
        drive(1, 1'b1, 1'b0, 7, 0);
        step();
        drain();
        chk("rbw_old_data", 32'(last_d[1]), 32'h4);
        chk("rbw_wr_completion", 32'(last_w[0]), 32'd1);
        drive(1, 1'b1, 1'b0, 7, 0);
        step();
        drain();
        chk("rbw_new_data", 32'(last_d[1]), 32'h9);

        // Streaming: back-to-back reads, addresses wrapping.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 32; i++) begin
            drive(0, 1'b1, 1'b0, (20 + i) % 32, 0);
            drive(1, 1'b1, 1'b0, (31 + i) % 32, 0);
            step();
            if (acc[0]) n0++;
            if (acc[1]) n1++;
        end
        chk("stream_p0_count", 32'(n0), 32'd32);
        chk("stream_p1_count", 32'(n1), 32'd32);
        drain();

        // Random traffic on a small address window to provoke collisions.
        hv[0] = 1'b0;
        hv[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hv[p]) begin
                    hv[p]  = ($urandom_range(0, 3) != 0);
                    hwe[p] = 1'($urandom_range(0, 1));
                    ha[p]  = $urandom_range(0, 7);
                    hd[p]  = $urandom_range(0, 15);
                end
                drive(p, hv[p], hwe[p], ha[p], hd[p]);
            end
            resp_ready = 2'($urandom_range(0, 3));
            step();
            for (int p = 0; p < 2; p++) if (acc[p]) hv[p] = 1'b0;
        end
        drain();

        // Asynchronous reset with responses buffered and in flight.
        resp_ready = 2'b00;
        drive(0, 1'b1, 1'b1, 20, 4'hC);
        drive(1, 1'b1, 1'b0, 1, 0);
        step();
        drive(0, 1'b1, 1'b0, 20, 0);
        step();
        rst = 1'b1;
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("mrst_p%0d_resp_valid", p), 32'(resp_valid[p]), 32'd0);
            chk($sformatf("mrst_p%0d_req_ready", p), 32'(req_ready[p]), 32'd0);
            chk($sformatf("mrst_p%0d_resp_data", p), 32'(resp_data[p]), 32'd0);
            chk($sformatf("mrst_p%0d_ram_strobes", p), 32'({ram_wr_en[p], ram_rd_en[p]}), 32'd0);
        end
        q.delete();
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_rel_p0_ready", 32'(req_ready[0]), 32'd1);
        chk("mrst_rel_p1_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        resp_ready = 2'b11;
        repeat (3) step();
        drive(0, 1'b1, 1'b0, 20, 0);
        step();
        drain();
        chk("mrst_write_persists", 32'(last_d[0]), 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
